// File: rtl/fp_int_acc.sv
// fp_int_acc: aligns sign/exponent/mantissa products onto a wide signed
// fixed-point scale (LSB 2^-24), accumulates a group exactly, and on the
// last beat normalizes the sum to an fp32 word behind a valid/ready port.
module fp_int_acc #(
  parameter int MANT_WIDTH = 15,
  parameter int EXP_WIDTH  = 5,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  sign_in,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  input  logic [MANT_WIDTH-1:0] mant_in,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           result,
  output logic                  ovf,
  output logic                  nan
);

  localparam int PW  = $clog2(ACC_WIDTH);
  localparam int MSB = ACC_WIDTH - 1;

  typedef enum logic [1:0] {ST_ACC, ST_NORM, ST_OUT} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_r_q, ovf_r_d;
  logic                   ovf_sign_q, ovf_sign_d;
  logic                   nan_r_q, nan_r_d;
  logic [31:0]            result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   nan_q, nan_d;

  logic                   exp_zero, exp_special;
  logic [ACC_WIDTH-1:0]   mag, aligned, sum;
  logic                   add_ovf;

  logic                   acc_neg;
  logic [ACC_WIDTH-1:0]   acc_abs, acc_norm;
  logic [PW-1:0]          lead;
  logic [7:0]             fp_exp;
  logic [22:0]            fp_frac;
  logic [31:0]            fp_word;

  // Align the incoming product to the accumulator scale and form the sum.
  always_comb begin
    exp_zero    = (exp_in == '0);
    exp_special = (exp_in == '1);
    mag         = '0;
    if (!exp_zero && !exp_special)
      mag = {{(ACC_WIDTH-MANT_WIDTH){1'b0}}, mant_in} << (exp_in - EXP_WIDTH'(1));
    aligned = sign_in ? -mag : mag;
    sum     = acc_q + aligned;
    add_ovf = (acc_q[MSB] == aligned[MSB]) && (sum[MSB] != acc_q[MSB]);
  end

  // Normalize the accumulator into an fp32 word, truncating the fraction.
  always_comb begin
    acc_neg = acc_q[MSB];
    acc_abs = acc_neg ? -acc_q : acc_q;
    lead    = '0;
    for (int unsigned i = 0; i < ACC_WIDTH; i++)
      if (acc_abs[i]) lead = PW'(i);
    // Shift the leading one up to the MSB so the fraction is a fixed slice.
    acc_norm = acc_abs << (PW'(MSB) - lead);
    fp_exp   = 8'(lead) + 8'd103;
    fp_frac  = acc_norm[MSB-1 -: 23];
    if (nan_r_q)
      fp_word = 32'h7FC0_0000;
    else if (ovf_r_q)
      fp_word = ovf_sign_q ? 32'hFF80_0000 : 32'h7F80_0000;
    else if (acc_q == '0)
      fp_word = '0;
    else
      fp_word = {acc_neg, fp_exp, fp_frac};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (in_valid && in_last) state_d = ST_NORM;
      ST_NORM: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Accumulator, sticky flags and result register updates.
  always_comb begin
    acc_d      = acc_q;
    ovf_r_d    = ovf_r_q;
    ovf_sign_d = ovf_sign_q;
    nan_r_d    = nan_r_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    nan_d      = nan_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d = sum;
          if (add_ovf) begin
            ovf_r_d    = 1'b1;
            ovf_sign_d = aligned[MSB];
          end
          if (exp_special) nan_r_d = 1'b1;
        end
      end
      ST_NORM: begin
        result_d = fp_word;
        ovf_d    = ovf_r_q;
        nan_d    = nan_r_q;
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d      = '0;
          ovf_r_d    = 1'b0;
          ovf_sign_d = 1'b0;
          nan_r_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      ovf_r_q    <= 1'b0;
      ovf_sign_q <= 1'b0;
      nan_r_q    <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      nan_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_r_q    <= ovf_r_d;
      ovf_sign_q <= ovf_sign_d;
      nan_r_q    <= nan_r_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      nan_q      <= nan_d;
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_OUT);
    result    = result_q;
    ovf       = ovf_q;
    nan       = nan_q;
  end

endmodule

// File: tb/tb_fp_int_acc.sv
// Bench for fp_int_acc: directed vector table, hand-written handshake and
// reset sequences, and randomized groups against an arithmetic model.
module tb_fp_int_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, sign_in, out_ready;
  logic [4:0]  exp_in;
  logic [14:0] mant_in;
  logic        in_ready, out_valid, ovf, nan;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp_int_acc #(.MANT_WIDTH(15), .EXP_WIDTH(5), .ACC_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .nan(nan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        s;
    bit [4:0]  e;
    bit [14:0] m;
    bit        last;
    bit [31:0] res;
    bit        eovf;
    bit        enan;
    string     name;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: exact group sum kept in a 48-bit signed range.
  localparam longint ACC_MAX = (longint'(1) <<< 47) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 47);
  localparam longint WRAP    = longint'(1) <<< 48;
  longint m_acc;
  bit     m_ovf, m_osign, m_nan;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  function automatic void add_vec(input bit s, input bit [4:0] e, input bit [14:0] m,
                                  input bit last, input bit [31:0] res,
                                  input bit eovf, input bit enan, input string name);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.last = last;
    v.res = res; v.eovf = eovf; v.enan = enan; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic model_clear();
    m_acc = 0; m_ovf = 0; m_osign = 0; m_nan = 0;
  endtask

  // value = (-1)^s * m * 2^(e-25); in units of 2^-24 that is m * 2^(e-1).
  task automatic model_beat(input bit s, input bit [4:0] e, input bit [14:0] m);
    longint a;
    longint t;
    if (e == 0) return;
    if (e == 31) begin
      m_nan = 1;
      return;
    end
    a = longint'(m) * (longint'(1) <<< (int'(e) - 1));
    if (s) a = -a;
    t = m_acc + a;
    if (t > ACC_MAX) begin
      m_ovf = 1; m_osign = s; t = t - WRAP;
    end else if (t < ACC_MIN) begin
      m_ovf = 1; m_osign = s; t = t + WRAP;
    end
    m_acc = t;
  endtask

  function automatic bit [31:0] model_result();
    longint    mag;
    int        p;
    bit [22:0] frac;
    bit [7:0]  ex;
    if (m_nan) return 32'h7FC0_0000;
    if (m_ovf) return m_osign ? 32'hFF80_0000 : 32'h7F80_0000;
    if (m_acc == 0) return 32'h0;
    mag = (m_acc < 0) ? -m_acc : m_acc;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p >= 23) frac = 23'(mag >> (p - 23));
    else         frac = 23'(mag << (23 - p));
    ex = 8'(p - 24 + 127);
    return {(m_acc < 0), ex, frac};
  endfunction

  task automatic beat(input bit s, input bit [4:0] e, input bit [14:0] m, input bit last);
    in_valid = 1'b1; sign_in = s; exp_in = e; mant_in = m; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input bit [31:0] eres, input bit eovf, input bit enan,
                         input string name, input int delay);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid never rose", name);
      return;
    end
    check32({name, "_result"}, result, eres);
    check1({name, "_ovf"}, ovf, eovf);
    check1({name, "_nan"}, nan, enan);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_last = 0; sign_in = 0; exp_in = 0; mant_in = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_result", result, 32'h0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_nan", nan, 1'b0);

    // Latency and turnaround of a single-beat group.
    @(posedge clk); #1;
    beat(0, 15, 15'h400, 1);
    @(negedge clk);
    check1("lat_norm_out_valid", out_valid, 1'b0);
    check1("lat_norm_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check1("lat_out_valid", out_valid, 1'b1);
    check32("lat_result", result, 32'h3F80_0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check1("lat_in_ready_back", in_ready, 1'b1);
    check1("lat_out_valid_drop", out_valid, 1'b0);

    // Directed vector table; expected values apply only on last beats.
    add_vec(0, 15, 15'h400,  1, 32'h3F80_0000, 0, 0, "one");
    add_vec(0, 15, 15'h400,  0, 32'h0,         0, 0, "");
    add_vec(1, 15, 15'h400,  1, 32'h0000_0000, 0, 0, "cancel");
    add_vec(0, 16, 15'h1C00, 1, 32'h4160_0000, 0, 0, "fourteen");
    add_vec(0, 1,  15'h001,  1, 32'h3380_0000, 0, 0, "min_lsb");
    add_vec(1, 30, 15'h7FFF, 1, 32'hC97F_FE00, 0, 0, "max_neg");
    add_vec(0, 0,  15'h7FFF, 1, 32'h0000_0000, 0, 0, "ftz");
    add_vec(0, 14, 15'h400,  0, 32'h0,         0, 0, "");
    add_vec(0, 13, 15'h400,  1, 32'h3F40_0000, 0, 0, "three_q");
    add_vec(0, 15, 15'h400,  0, 32'h0,         0, 0, "");
    add_vec(0, 0,  15'h7FFF, 0, 32'h0,         0, 0, "");
    add_vec(1, 14, 15'h400,  1, 32'h3F00_0000, 0, 0, "half");
    add_vec(0, 31, 15'h000,  0, 32'h0,         0, 0, "");
    add_vec(0, 15, 15'h400,  1, 32'h7FC0_0000, 0, 1, "nan");
    for (int i = 0; i < 9; i++)
      add_vec(0, 30, 15'h7FFF, (i == 8), 32'h7F80_0000, 1, 0, "pos_ovf");
    for (int i = 0; i < 9; i++)
      add_vec(1, 30, 15'h7FFF, (i == 8), 32'hFF80_0000, 1, 0, "neg_ovf");
    add_vec(0, 15, 15'h400,  1, 32'h3F80_0000, 0, 0, "after_ovf");

    foreach (vecs[i]) begin
      beat(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].last);
      if (vecs[i].last)
        collect(vecs[i].res, vecs[i].eovf, vecs[i].enan, vecs[i].name, 0);
    end

    // Backpressure: result held, input beats ignored while not ready.
    beat(0, 15, 15'h400, 1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check1("bp_out_valid", out_valid, 1'b1);
      check32("bp_result", result, 32'h3F80_0000);
      check1("bp_in_ready", in_ready, 1'b0);
      in_valid = 1'b1; sign_in = 0; exp_in = 20; mant_in = 15'h7FFF; in_last = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    collect(32'h3F80_0000, 0, 0, "bp_final", 0);
    beat(0, 15, 15'h400, 1);
    collect(32'h3F80_0000, 0, 0, "bp_next", 0);

    // Reset in the middle of a group discards accumulated beats.
    beat(0, 20, 15'h1234, 0);
    beat(1, 30, 15'h7FFF, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rstmid_out_valid", out_valid, 1'b0);
    check1("rstmid_in_ready", in_ready, 1'b1);
    beat(0, 15, 15'h400, 1);
    collect(32'h3F80_0000, 0, 0, "rstmid", 0);

    // Reset while a result is pending.
    beat(1, 16, 15'h1C00, 1);
    @(negedge clk);
    @(negedge clk);
    check1("rstout_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rstout_out_valid", out_valid, 1'b0);
    check1("rstout_in_ready", in_ready, 1'b1);
    check32("rstout_result", result, 32'h0);
    beat(0, 14, 15'h400, 1);
    collect(32'h3F00_0000, 0, 0, "rstout_next", 0);

    // Randomized groups against the model.
    for (int g = 0; g < 200; g++) begin
      bit big, gs, s, last;
      bit [4:0] e;
      bit [14:0] m;
      int nb, r;
      big = ($urandom_range(0, 7) == 0);
      gs  = 1'($urandom_range(0, 1));
      nb  = big ? $urandom_range(8, 12) : $urandom_range(1, 8);
      model_clear();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_last = 1'($urandom_range(0, 1));
          exp_in = 5'($urandom); mant_in = 15'($urandom); sign_in = 1'($urandom);
          @(posedge clk); #1;
          in_last = 1'b0;
        end
        if (big) begin
          s = gs; e = 5'd30; m = 15'h7000 | 15'($urandom);
        end else begin
          s = 1'($urandom_range(0, 1));
          m = 15'($urandom);
          r = $urandom_range(0, 99);
          if (r < 8)       e = 5'd0;
          else if (r < 11) e = 5'd31;
          else             e = 5'($urandom_range(1, 30));
        end
        last = (b == nb - 1);
        model_beat(s, e, m);
        beat(s, e, m, last);
      end
      collect(model_result(), m_ovf, m_nan, "rand", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
